// File: rtl/merge_head_collector_if.sv
// merge_head_collector_if: input and output stream handshakes of the head collector
interface merge_head_collector_if #(
   parameter int DATA_WIDTH = 8,
   parameter int HEAD_DIM   = 64
);
   localparam int W = DATA_WIDTH * HEAD_DIM;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_last;
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/merge_head_collector.sv
// merge_head_collector: buffers a head-major frame and re-emits it token-major
module merge_head_collector #(
   parameter int DATA_WIDTH = 8,
   parameter int SEQ_LEN    = 128,
   parameter int HEADS      = 12,
   parameter int HEAD_DIM   = 64
) (
   input  logic                  clk_p,
   input  logic                  rst_n,
   input  logic                  sw_clr,
   merge_head_collector_if.slave bus,
   output logic                  frame_done
);
   localparam int W     = DATA_WIDTH * HEAD_DIM;
   localparam int TOTAL = SEQ_LEN * HEADS;
   localparam int AW    = $clog2(TOTAL);
   localparam int CW    = $clog2(TOTAL + 1);
   localparam int TW    = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam int HW    = (HEADS > 1) ? $clog2(HEADS) : 1;

   typedef enum logic {FILL, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] in_tok_q, in_tok_d;
   logic [HW-1:0] in_head_q, in_head_d;
   logic [CW-1:0] rd_cnt_q, rd_cnt_d;
   logic [W-1:0]  out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          out_last_q, out_last_d;
   logic          frame_done_q, frame_done_d;
   logic [W-1:0]  mem_q [TOTAL];
   logic [AW-1:0] wr_addr;
   logic          in_fire, consume, load, last_tok, last_head;

   assign bus.in_ready  = state_q == FILL;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign frame_done    = frame_done_q;

   assign in_fire   = bus.in_valid && bus.in_ready && !sw_clr;
   assign consume   = out_valid_q && bus.out_ready;
   assign load      = state_q == DRAIN && rd_cnt_q < CW'(TOTAL) && (!out_valid_q || bus.out_ready);
   assign last_tok  = in_tok_q == TW'(SEQ_LEN - 1);
   assign last_head = in_head_q == HW'(HEADS - 1);
   assign wr_addr   = AW'(in_tok_q * HEADS + in_head_q);

   // frame buffer: token-major slot for each head-major input beat
   always_ff @(posedge clk_p) begin
      if (in_fire) mem_q[wr_addr] <= bus.in_data;
   end

   // state, counters and output register
   always_ff @(posedge clk_p or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= FILL;
         in_tok_q     <= '0;
         in_head_q    <= '0;
         rd_cnt_q     <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_tok_q     <= in_tok_d;
         in_head_q    <= in_head_d;
         rd_cnt_q     <= rd_cnt_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // next state: fill counters, drain handshake, abort on sw_clr
   always_comb begin
      state_d      = state_q;
      in_tok_d     = in_tok_q;
      in_head_d    = in_head_q;
      rd_cnt_d     = rd_cnt_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      frame_done_d = 1'b0;
      if (sw_clr) begin
         state_d     = FILL;
         in_tok_d    = '0;
         in_head_d   = '0;
         rd_cnt_d    = '0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end else if (state_q == FILL) begin
         if (in_fire) begin
            in_tok_d  = last_tok ? '0 : in_tok_q + 1'b1;
            in_head_d = last_tok ? (last_head ? '0 : in_head_q + 1'b1) : in_head_q;
            if (last_tok && last_head) begin
               state_d  = DRAIN;
               rd_cnt_d = '0;
            end
         end
      end else if (load) begin
         out_data_d  = mem_q[rd_cnt_q[AW-1:0]];
         out_valid_d = 1'b1;
         out_last_d  = rd_cnt_q == CW'(TOTAL - 1);
         rd_cnt_d    = rd_cnt_q + 1'b1;
      end else if (consume) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         if (out_last_q) begin
            state_d      = FILL;
            frame_done_d = 1'b1;
            rd_cnt_d     = '0;
         end
      end
   end
endmodule

// File: tb/tb_merge_head_collector.sv
// tb_merge_head_collector: scoreboard bench for the head-major to token-major reorder
module tb_merge_head_collector;
   logic clk_p, rst_n, sw_clr, frame_done;
   logic rnd;
   int   n_chk, n_fail, n_out, fd_cnt;
   logic [16:0] q [$];
   logic        stall, fd_exp;
   logic [15:0] held;
   logic [16:0] e;
   // token-major golden beats for key 0: beat k = token k/3, head k%3
   logic [15:0] tbl [12] = '{16'h0100, 16'h1110, 16'h2120, 16'h0504, 16'h1514, 16'h2524,
                             16'h0908, 16'h1918, 16'h2928, 16'h0D0C, 16'h1D1C, 16'h2D2C};

   merge_head_collector_if #(.DATA_WIDTH(8), .HEAD_DIM(2)) bus ();

   merge_head_collector #(.DATA_WIDTH(8), .SEQ_LEN(4), .HEADS(3), .HEAD_DIM(2)) dut (
      .clk_p(clk_p), .rst_n(rst_n), .sw_clr(sw_clr), .bus(bus), .frame_done(frame_done)
   );

   initial clk_p = 1'b0;
   always #5 clk_p = ~clk_p;

   always @(posedge clk_p) begin
      #1;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // monitor: pops the scoreboard on every consumed beat
   always @(negedge clk_p) begin
      if (!rst_n) begin
         stall  = 1'b0;
         fd_exp = 1'b0;
      end else begin
         if (stall) check("hold", {bus.out_valid, bus.out_data}, {1'b1, held});
         if (frame_done || fd_exp) check("frame_done", frame_done, fd_exp);
         if (frame_done) fd_cnt++;
         fd_exp = bus.out_valid && bus.out_ready && bus.out_last && !sw_clr;
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) fail_now("unexpected_beat");
            else begin
               e = q.pop_front();
               check("out_data", bus.out_data, e[15:0]);
               check("out_last", bus.out_last, e[16]);
            end
            n_out++;
         end
         stall = bus.out_valid && !bus.out_ready && !sw_clr;
         held  = bus.out_data;
      end
   end

   task automatic send_frame(input logic [7:0] key, input bit bub, input int nb);
      int   k = 0;
      logic acc;
      for (int h = 0; h < 3; h++)
         for (int t = 0; t < 4; t++) begin
            if (k < nb) begin
               if (bub && $urandom_range(0, 1) == 1) begin
                  bus.in_valid = 1'b0;
                  @(posedge clk_p); #1;
               end
               bus.in_valid = 1'b1;
               bus.in_data  = tbl[t*3+h] ^ {key, key};
               acc = 1'b0;
               for (int i = 0; i < 100 && !acc; i++) begin
                  acc = bus.in_ready;
                  @(posedge clk_p); #1;
               end
               if (!acc) fail_now("in_accept");
            end
            k++;
         end
      bus.in_valid = 1'b0;
      if (nb == 12)
         for (int j = 0; j < 12; j++) q.push_back({j == 11, tbl[j] ^ {key, key}});
   endtask

   task automatic wait_fd();
      for (int i = 0; i < 300; i++) begin
         if (frame_done) return;
         @(posedge clk_p); #1;
      end
      fail_now("frame_done_wait");
   endtask

   task automatic wait_out(input int n);
      for (int i = 0; i < 300; i++) begin
         if (n_out >= n) return;
         @(posedge clk_p); #1;
      end
      fail_now("out_wait");
   endtask

   task automatic check_reset_vals();
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_out_data", bus.out_data, 0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; sw_clr = 1'b0; rnd = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      #12;
      check_reset_vals();
      rst_n = 1'b1;
      @(posedge clk_p); #1;
      // streaming frame with latency check
      send_frame(8'h00, 0, 12);
      check("drain_out_valid_T", bus.out_valid, 0);
      check("drain_in_ready_T", bus.in_ready, 0);
      @(posedge clk_p); #1;
      check("first_valid_T1", bus.out_valid, 1);
      wait_fd();
      // output back-pressure
      rnd = 1'b1;
      send_frame(8'h80, 0, 12);
      wait_fd();
      rnd = 1'b0;
      @(posedge clk_p); #1;
      // input bubbles, junk presented during drain must be ignored
      base = n_out;
      send_frame(8'h40, 1, 12);
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      for (int i = 0; i < 300 && n_out < base + 12; i++) begin
         check("drain_in_ready", bus.in_ready, 0);
         @(posedge clk_p); #1;
      end
      bus.in_valid = 1'b0;
      wait_fd();
      @(posedge clk_p); #1;
      // two back-to-back frames, second starts in the frame_done cycle
      send_frame(8'h20, 0, 12);
      wait_fd();
      check("refill_in_ready", bus.in_ready, 1);
      send_frame(8'hA0, 0, 12);
      wait_fd();
      @(posedge clk_p); #1;
      // sw_clr after five input beats, then a full frame
      send_frame(8'h60, 0, 5);
      sw_clr = 1'b1;
      @(posedge clk_p); #1;
      sw_clr = 1'b0;
      check("clr_fill_in_ready", bus.in_ready, 1);
      check("clr_fill_out_valid", bus.out_valid, 0);
      send_frame(8'hE0, 0, 12);
      wait_fd();
      @(posedge clk_p); #1;
      // sw_clr while output beat 6 is presented
      base = n_out;
      send_frame(8'h10, 0, 12);
      wait_out(base + 6);
      sw_clr = 1'b1;
      @(posedge clk_p); #1;
      sw_clr = 1'b0;
      q.delete();
      check("clr_out_valid", bus.out_valid, 0);
      check("clr_in_ready", bus.in_ready, 1);
      check("clr_frame_done", frame_done, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk_p); #1;
         check("clr_quiet", {bus.out_valid, frame_done}, 0);
      end
      // asynchronous reset mid-drain
      base = n_out;
      send_frame(8'h90, 0, 12);
      wait_out(base + 3);
      #1;
      rst_n = 1'b0;
      #1;
      check_reset_vals();
      q.delete();
      #2;
      rst_n = 1'b1;
      repeat (3) @(posedge clk_p);
      #1;
      check("end_queue_empty", q.size(), 0);
      check("end_frame_done_count", fd_cnt, 6);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/merge_head_collector.md
# merge_head_collector

Streaming stage that sits directly upstream of the head-merge stage. Attention results arrive head-major: all tokens of head 0, then all tokens of head 1, and so on. The block buffers one full frame and re-emits it token-major: token 0 heads 0..HEADS-1, then token 1, and so on. Concatenating one token's HEADS output beats gives that token's merged row (SEQ_LEN x HEADS·HEAD_DIM).

## Interface
- DATA_WIDTH, 8, bits per signed element
- SEQ_LEN, 128, tokens per frame
- HEADS, 12, attention heads
- HEAD_DIM, 64, elements per head slice

Ports:
- clk_p  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- sw_clr  input  1  synchronous abort: return to FILL with counters cleared
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_data  input  DATA_WIDTH·HEAD_DIM  one token's slice of one head; element 0 in the LSBs
- out_valid  output  1  output beat valid
- out_ready  input  1  output beat consumed when out_valid && out_ready
- out_data  output  DATA_WIDTH·HEAD_DIM  one head slice of one token
- out_last  output  1  high with the final beat of the frame
- frame_done  output  1  one-cycle pulse, the cycle after the final output beat is consumed

## Operation
- Definitions:
  - TOTAL = SEQ_LEN·HEADS.
  - Buffer: TOTAL entries of DATA_WIDTH·HEAD_DIM bits, read combinationally, written synchronously.
- State FILL (the reset state):
  - in_ready=1 and out_valid=0.
  - Counters in_tok (0..SEQ_LEN-1) and in_head (0..HEADS-1); in_tok is the fast index.
  - On each accepted beat, write buffer[in_tok·HEADS + in_head].
  - in_tok wraps to 0 and in_head increments.
  - When the beat with in_tok=SEQ_LEN-1 and in_head=HEADS-1 is accepted: go to DRAIN and clear rd_cnt.
- State DRAIN:
  - in_ready=0.
  - The output register loads buffer[rd_cnt] when rd_cnt<TOTAL and (!out_valid || out_ready). rd_cnt increments on each load.
  - out_valid is set on a load. It clears when the beat is consumed and no new load occurs in the same cycle.
  - out_last is registered with the load, high when rd_cnt = TOTAL-1.
  - When the out_last beat is consumed: go to FILL, pulse frame_done next cycle, clear all counters.
- out_data holds stable while out_valid && !out_ready.
- sw_clr:
  - Overrides everything: state=FILL, all counters 0, out_valid=0, out_last=0, frame_done=0.
  - An in-flight input or output beat in that cycle is discarded.
  - Buffer contents are not cleared.
- Data passes through bit-exact; no arithmetic. Signedness is irrelevant to the block.

## Timing
- Reset values: in_ready=1, out_valid=0, out_last=0, frame_done=0, out_data=0; state FILL.
- Input throughput: 1 beat/cycle in FILL.
- Last input accepted at edge T: state is DRAIN after T; first out_valid high after T+1.
- Output throughput: 1 beat/cycle with out_ready held high. The full frame drains in TOTAL cycles.
- Last output consumed at edge U:
  - After U: state FILL, in_ready=1, out_valid=0.
  - frame_done is high for the cycle after U, deasserting at U+1.
- Back-pressure: out_ready=0 stalls rd_cnt; no beat is lost or duplicated.
- in_valid during DRAIN is ignored because in_ready=0. The upstream holds its data.
- rst_n asserted mid-frame: all state clears immediately and asynchronously.

## Test plan
Common bench setup: SEQ_LEN=4, HEADS=3, HEAD_DIM=2, DATA_WIDTH=8. Element e of head h, token t = h·16+t·4+e.

- Streaming frame: 12 input beats back-to-back with out_ready=1.
  - Output beats k=0..11 carry token k/3, head k%3. Beat 0 = {0x01,0x00}, beat 1 = {0x11,0x10}, beat 3 = {0x05,0x04}.
  - out_last only on beat 11 ({0x2D,0x2C}).
  - frame_done pulses once.
  - First out_valid 2 cycles after the last input edge.
- Output back-pressure: toggle out_ready randomly at 50%.
  - Identical 12-beat sequence.
  - out_data stable while stalled.
- Input bubbles: in_valid toggled at 50% duty.
  - Same output sequence.
  - in_ready=0 throughout DRAIN.
- Two consecutive frames with different data.
  - Second frame accepted starting the cycle after frame_done rises.
  - Second frame's output is correct and contains no first-frame data.
- sw_clr after 5 input beats, then a full new frame.
  - Output matches the new frame only.
- sw_clr during DRAIN on output beat 6.
  - out_valid=0 the next cycle, in_ready=1, no frame_done.
- rst_n pulse mid-DRAIN.
  - All outputs return to their reset values immediately.
